// File: rtl/jtframe_kabuki2_if.sv
// jtframe_kabuki2_if: Z80 bus, key programming and decoded output of the Kabuki decoder
interface jtframe_kabuki2_if;
  logic        m1_n;
  logic        rd_n;
  logic        mreq_n;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        en;
  logic [1:0]  key_sel;
  logic [7:0]  prog_data;
  logic        prog_we;
  logic        key_clr;
  logic        key_ok;
  logic [7:0]  dout;
  logic        dout_ok;
  modport master(
    output m1_n, rd_n, mreq_n, addr, din, en, key_sel, prog_data, prog_we, key_clr,
    input  key_ok, dout, dout_ok
  );
  modport slave(
    input  m1_n, rd_n, mreq_n, addr, din, en, key_sel, prog_data, prog_we, key_clr,
    output key_ok, dout, dout_ok
  );
endinterface

// File: rtl/jtframe_kabuki2.sv
// jtframe_kabuki2: Kabuki Z80 opcode/data decryption with serially loaded key sets
module jtframe_kabuki2 #(
  parameter int          KEYS     = 1,
  parameter int          PIPE     = 0,
  parameter logic [15:0] DATA_XOR = 16'h1fc0
) (
  input logic             clk,
  input logic             rst,
  jtframe_kabuki2_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, LOAD, READY} st_t;
  st_t         st, st_nx;
  logic [3:0]  byte_cnt, byte_nx;
  logic [1:0]  set_cnt, set_nx;
  logic        load, last_set, key_ok_r, en_q, active;
  logic [1:0]  sel_q;
  logic [15:0] addr_hit, addr_key;
  logic [87:0] keys [4];
  logic [31:0] s1, s2;
  logic [7:0]  xk, lo, hi, d1, d2, d3, dec;

  function automatic logic [7:0] swap_a(input logic [7:0] d, input logic [15:0] k, input logic [7:0] h);
    logic [7:0] r;
    r = d;
    for (int p = 0; p < 4; p++) if (h[k[4*p+:3]]) r[2*p+:2] = {d[2*p], d[2*p+1]};
    return r;
  endfunction

  function automatic logic [7:0] swap_b(input logic [7:0] d, input logic [15:0] k, input logic [7:0] h);
    logic [7:0] r;
    r = d;
    for (int p = 0; p < 4; p++) if (h[k[4*(3-p)+:3]]) r[2*p+:2] = {d[2*p], d[2*p+1]};
    return r;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] d);
    return {d[6:0], d[7]};
  endfunction

  assign last_set = 32'(set_cnt) == KEYS - 1;

  always_comb begin
    st_nx   = st;
    byte_nx = byte_cnt;
    set_nx  = set_cnt;
    load    = 1'b0;
    if (bus.key_clr) begin
      st_nx   = EMPTY;
      byte_nx = '0;
      set_nx  = '0;
    end else if (bus.prog_we && st != READY) begin
      load    = 1'b1;
      byte_nx = byte_cnt == 4'd10 ? 4'd0 : byte_cnt + 4'd1;
      set_nx  = byte_cnt != 4'd10 ? set_cnt : last_set ? 2'd0 : set_cnt + 2'd1;
      st_nx   = byte_cnt == 4'd10 && last_set ? READY : LOAD;
    end
  end

  assign addr_key = keys[bus.key_sel][23:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= EMPTY;
      byte_cnt <= '0;
      set_cnt  <= '0;
      key_ok_r <= 1'b0;
      en_q     <= 1'b0;
      sel_q    <= '0;
      addr_hit <= '0;
    end else begin
      st       <= st_nx;
      byte_cnt <= byte_nx;
      set_cnt  <= set_nx;
      key_ok_r <= st_nx == READY;
      en_q     <= bus.en;
      sel_q    <= bus.key_sel;
      addr_hit <= bus.m1_n ? (bus.addr ^ DATA_XOR) + addr_key + 16'd1 : bus.addr + addr_key;
    end
  end

  // key storage survives reset; key_ok gates its use
  always_ff @(posedge clk) if (!rst && load) keys[set_cnt] <= {keys[set_cnt][79:0], bus.prog_data};

  assign s1     = keys[sel_q][87:56];
  assign s2     = keys[sel_q][55:24];
  assign xk     = keys[sel_q][7:0];
  assign lo     = addr_hit[7:0];
  assign hi     = addr_hit[15:8];
  assign active = !bus.mreq_n && !bus.rd_n && en_q && key_ok_r && 32'(sel_q) < KEYS;
  assign d1     = rol(swap_a(bus.din, s1[15:0], lo));
  assign d2     = rol(swap_b(d1, s1[31:16], lo) ^ xk);
  assign d3     = rol(swap_b(d2, s2[15:0], hi));
  assign dec    = active ? swap_a(d3, s2[31:16], hi) : bus.din;
  assign bus.key_ok = key_ok_r;

  if (PIPE != 0) begin : g_pipe
    logic [7:0] dout_r;
    logic       ok_r;
    always_ff @(posedge clk) begin
      dout_r <= rst ? 8'd0 : dec;
      ok_r   <= rst ? 1'b0 : active;
    end
    assign bus.dout    = dout_r;
    assign bus.dout_ok = ok_r;
  end else begin : g_comb
    assign bus.dout    = dec;
    assign bus.dout_ok = active;
  end
endmodule

// File: tb/tb_jtframe_kabuki2.sv
// tb_jtframe_kabuki2: directed checks of key loading and decoding, combinational and pipelined builds
module tb_jtframe_kabuki2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  jtframe_kabuki2_if a();
  jtframe_kabuki2_if b();

  jtframe_kabuki2 #(.KEYS(1), .PIPE(0)) u_a(.clk(clk), .rst(rst), .bus(a));
  jtframe_kabuki2 #(.KEYS(2), .PIPE(1)) u_b(.clk(clk), .rst(rst), .bus(b));

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit u, input logic [7:0] d);
    if (u) begin b.prog_data = d; b.prog_we = 1'b1; end
    else begin a.prog_data = d; a.prog_we = 1'b1; end
    step();
    a.prog_we = 1'b0;
    b.prog_we = 1'b0;
  endtask

  task automatic rd_a(input logic m1, input logic [15:0] ad, input logic [7:0] d);
    a.m1_n = m1; a.addr = ad; a.din = d; a.mreq_n = 1'b0; a.rd_n = 1'b0;
    step();
  endtask

  task automatic init_bus();
    a.m1_n = 1; a.rd_n = 1; a.mreq_n = 1; a.addr = 0; a.din = 0; a.en = 0;
    a.key_sel = 0; a.prog_data = 0; a.prog_we = 0; a.key_clr = 0;
    b.m1_n = 1; b.rd_n = 1; b.mreq_n = 1; b.addr = 0; b.din = 0; b.en = 0;
    b.key_sel = 0; b.prog_data = 0; b.prog_we = 0; b.key_clr = 0;
  endtask

  logic [7:0] swap_key [11] = '{8'h20, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00};

  initial begin
    init_bus();
    step();
    step();
    check("rst_key_ok_a", 16'(a.key_ok), 16'd0);
    check("rst_dout_ok_a", 16'(a.dout_ok), 16'd0);
    check("rst_addr_hit_a", u_a.addr_hit, 16'h0000);
    check("rst_key_ok_b", 16'(b.key_ok), 16'd0);
    check("rst_dout_b", 16'(b.dout), 16'h00);
    check("rst_dout_ok_b", 16'(b.dout_ok), 16'd0);
    rst = 1'b0;

    a.en = 1'b1;
    rd_a(1'b0, 16'h0000, 8'hA5);
    check("preload_dout", 16'(a.dout), 16'h00A5);
    check("preload_ok", 16'(a.dout_ok), 16'd0);
    a.mreq_n = 1'b1;

    for (int i = 0; i < 10; i++) wr(1'b0, 8'h00);
    check("zero10_key_ok", 16'(a.key_ok), 16'd0);
    wr(1'b0, 8'h00);
    check("zero11_key_ok", 16'(a.key_ok), 16'd1);
    rd_a(1'b0, 16'h0000, 8'h01);
    check("m1_zero_dout", 16'(a.dout), 16'h0008);
    check("m1_zero_ok", 16'(a.dout_ok), 16'd1);
    rd_a(1'b1, 16'h0000, 8'h01);
    check("data_addr_hit", u_a.addr_hit, 16'h1fc1);
    check("data_zero_dout", 16'(a.dout), 16'h0080);

    a.key_clr = 1'b1;
    step();
    a.key_clr = 1'b0;
    check("clr_key_ok", 16'(a.key_ok), 16'd0);
    check("clr_bypass_dout", 16'(a.dout), 16'h0001);
    check("clr_bypass_ok", 16'(a.dout_ok), 16'd0);
    a.mreq_n = 1'b1;

    for (int i = 0; i < 10; i++) wr(1'b0, 8'h00);
    check("xor10_key_ok", 16'(a.key_ok), 16'd0);
    wr(1'b0, 8'hFF);
    check("xor11_key_ok", 16'(a.key_ok), 16'd1);
    rd_a(1'b0, 16'h0000, 8'h00);
    check("xor_dout", 16'(a.dout), 16'h00FF);
    a.mreq_n = 1'b1;
    wr(1'b0, 8'h12);
    check("ready_we_key_ok", 16'(a.key_ok), 16'd1);
    rd_a(1'b0, 16'h0000, 8'h00);
    check("ready_we_dout", 16'(a.dout), 16'h00FF);
    a.mreq_n = 1'b1;

    a.key_clr = 1'b1;
    step();
    a.key_clr = 1'b0;
    for (int i = 0; i < 5; i++) wr(1'b0, 8'h33);
    check("partial_key_ok", 16'(a.key_ok), 16'd0);
    a.key_clr = 1'b1;
    wr(1'b0, 8'h77);
    a.key_clr = 1'b0;
    for (int i = 0; i < 10; i++) wr(1'b0, swap_key[i]);
    check("reload10_key_ok", 16'(a.key_ok), 16'd0);
    wr(1'b0, swap_key[10]);
    check("reload11_key_ok", 16'(a.key_ok), 16'd1);
    rd_a(1'b0, 16'h0002, 8'h02);
    check("swap_addr_hit", u_a.addr_hit, 16'h0006);
    check("swap_dout", 16'(a.dout), 16'h0004);
    a.en = 1'b0;
    rd_a(1'b0, 16'h0002, 8'h02);
    check("en_off_dout", 16'(a.dout), 16'h0002);
    check("en_off_ok", 16'(a.dout_ok), 16'd0);
    a.mreq_n = 1'b1;

    b.en = 1'b1;
    for (int i = 0; i < 11; i++) wr(1'b1, 8'h00);
    check("b_set0_key_ok", 16'(b.key_ok), 16'd0);
    for (int i = 0; i < 10; i++) wr(1'b1, 8'h00);
    wr(1'b1, 8'h5A);
    check("b_set1_key_ok", 16'(b.key_ok), 16'd1);

    b.key_sel = 2'd3; b.m1_n = 1'b0; b.addr = 16'h0000; b.din = 8'h3C;
    b.mreq_n = 1'b0; b.rd_n = 1'b0;
    step();
    step();
    check("b_sel3_dout", 16'(b.dout), 16'h003C);
    check("b_sel3_ok", 16'(b.dout_ok), 16'd0);

    b.mreq_n = 1'b1; b.rd_n = 1'b1; b.key_sel = 2'd1; b.din = 8'h00;
    step();
    b.mreq_n = 1'b0; b.rd_n = 1'b0;
    #1;
    check("b_sel1_ok_before", 16'(b.dout_ok), 16'd0);
    step();
    check("b_sel1_dout", 16'(b.dout), 16'h0069);
    check("b_sel1_ok", 16'(b.dout_ok), 16'd1);
    b.key_sel = 2'd0; b.din = 8'h01;
    step();
    step();
    check("b_sel0_dout", 16'(b.dout), 16'h0008);
    check("b_sel0_ok", 16'(b.dout_ok), 16'd1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rerst_key_ok", 16'(a.key_ok), 16'd0);
    a.en = 1'b1;
    rd_a(1'b0, 16'h0002, 8'h02);
    check("rerst_dout", 16'(a.dout), 16'h0002);
    check("rerst_ok", 16'(a.dout_ok), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jtframe_kabuki2.md
JTFRAME_KABUKI2 -- requirements
Module: jtframe_kabuki2

Interface
REQ-001 SHALL have parameter KEYS, default 1: number of stored key sets, 1..4.
REQ-002 SHALL have parameter PIPE, default 0: 0 gives combinational dout, 1 gives registered dout.
REQ-003 SHALL have parameter DATA_XOR, default 16'h1fc0: address XOR term for data (non-M1) reads.
REQ-004 SHALL have ports: clk  in  1  system clock, matches SDRAM clock; single clock domain.
REQ-005 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: m1_n, rd_n, mreq_n  in  1 each  Z80 bus strobes, active-low.
REQ-007 SHALL have ports: addr  in  16  CPU address; din  in  8  encrypted ROM byte.
REQ-008 SHALL have ports: en  in  1  decryption enable; key_sel  in  2  active key set.
REQ-009 SHALL have ports: prog_data  in  8  key byte; prog_we  in  1  key byte strobe; key_clr  in  1  discard keys.
REQ-010 SHALL have ports: key_ok  out  1  all KEYS sets loaded; dout  out  8  decoded byte; dout_ok  out  1  dout holds a decrypted value.

Function
REQ-011 SHALL hold one 88-bit key image per set; bytes arrive MSB first; fields: [87:56] swap1, [55:24] swap2, [23:8] addr_key, [7:0] xor_key.
REQ-012 SHALL run a loader FSM with states EMPTY, LOAD, READY and a byte counter 0..10 plus a set counter 0..KEYS-1.
REQ-013 SHALL, on prog_we in EMPTY or LOAD, shift prog_data into the current set, increment the byte counter and enter LOAD.
REQ-014 SHALL, on the 11th byte of a set, clear the byte counter and advance the set counter; after set KEYS-1 it SHALL enter READY.
REQ-015 SHALL ignore prog_we in READY; stored keys stay unchanged.
REQ-016 SHALL return to EMPTY with both counters cleared on key_clr; key_clr wins over a simultaneous prog_we, and that byte is dropped.
REQ-017 SHALL drive key_ok high only in READY, registered.
REQ-018 SHALL register every clk: en_q <= en, sel_q <= key_sel, addr_hit <= m1_n ? (addr^DATA_XOR)+addr_key[sel]+1 : addr+addr_key[sel], modulo 2^16.
REQ-019 SHALL define active = !mreq_n & !rd_n & en_q & key_ok & (sel_q < KEYS); when not active, the decode result SHALL equal din.
REQ-020 SHALL define swapA(d,k,h): 2-bit pair p (p=3 is bits 7:6, p=0 is bits 1:0) is swapped when h[k[4p+2:4p]]=1.
REQ-021 SHALL define swapB(d,k,h): as swapA, but pair p uses k[4(3-p)+2:4(3-p)].
REQ-022 SHALL decode in this order, with L=addr_hit[7:0], H=addr_hit[15:8], rot = rotate left 1:
  - swapA(swap1[15:0],L), rot
  - swapB(swap1[31:16],L), XOR xor_key, rot
  - swapB(swap2[15:0],H), rot
  - swapA(swap2[31:16],H)
REQ-023 SHALL, for PIPE=0, drive dout = decode result combinationally and dout_ok = active.
REQ-024 SHALL, for PIPE=1, register dout and dout_ok one clk after the decode inputs, giving latency 1.
REQ-025 SHALL, when key_clr occurs mid-operation, force bypass from the next cycle onward; bytes already registered under PIPE=1 complete unchanged.

Reset
REQ-026 SHALL, on rst, set: FSM=EMPTY, counters=0, key_ok=0, en_q=0, sel_q=0, addr_hit=0, registered dout=0, dout_ok=0.
REQ-027 SHALL NOT clear key storage on rst; keys are unusable until reloaded because key_ok=0.
REQ-028 SHALL give rst priority over key_clr and prog_we.

Verification
REQ-029 Before any load, bus read with en=1 and din=0xA5 -> dout=0xA5, dout_ok=0.
REQ-030 Load 11 bytes of 0x00 (KEYS=1); M1 read at addr 0x0000 with din=0x01 -> key_ok=1, dout=0x08.
REQ-031 Same all-zero keys, data read (m1_n=1) at addr 0x0000 with din=0x01 -> addr_hit=0x1fc1, dout=0x80.
REQ-032 Load 10 zero bytes then 0xFF; M1 read at addr 0 with din=0x00 -> dout=0xFF; a 12th prog_we is ignored and dout stays 0xFF.
REQ-033 key_clr asserted after 5 bytes, then 11 new bytes -> key_ok rises only after the 11th new byte.
REQ-034 KEYS=2 and PIPE=1, key_sel=3 -> bypass; key_sel=1 -> set-1 result appears one clk later with dout_ok=1.
